// File: rtl/lc3b_decode_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lc3b_decode_queue_if                                                       |
// | Instruction-in / micro-op-out handshake bundle for the LC-3b decode queue. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface lc3b_decode_queue_if #(
    parameter int DEPTH = 4
);
    // out_ctrl layout, MSB first: opcode[3:0] aluop[2:0] aluBmux immmux[1:0] sr2mux
    // wbdatamux[1:0] marmux[1:0] adjmux jsrmux dstmux regAmux load_cc load_dst
    localparam int CTRL_W = 21;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic [15:0]       in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [15:0]       out_instr;
    logic [15:0]       out_pc;
    logic              out_uop;
    logic [CNT_W-1:0]  count;
    logic              illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_instr, out_pc, out_uop, count, illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_ctrl, out_instr, out_pc, out_uop, count, illegal
    );
endinterface
`default_nettype wire

// File: rtl/lc3b_decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lc3b_decode_queue                                                          |
// | LC-3b decode stage: instruction -> control-word micro-ops, buffered in a   |
// | DEPTH-entry FIFO; LDI/STI optionally split into two micro-ops.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lc3b_decode_queue #(
    parameter int DEPTH  = 4,
    parameter int IND_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    lc3b_decode_queue_if.slave bus
);
    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } alu_ops;

    typedef struct packed {
        logic [3:0] opcode;
        alu_ops     aluop;
        logic       aluBmux;
        logic [1:0] immmux;
        logic       sr2mux;
        logic [1:0] wbdatamux;
        logic [1:0] marmux;
        logic       adjmux;
        logic       jsrmux;
        logic       dstmux;
        logic       regAmux;
        logic       load_cc;
        logic       load_dst;
    } lc3b_control_word;

    typedef struct packed {
        lc3b_control_word ctrl;
        logic [15:0]      instr;
        logic [15:0]      pc;
        logic             uop;
    } entry_t;

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    localparam logic [3:0] c_OP_BR  = 4'h0, c_OP_ADD = 4'h1, c_OP_LDB = 4'h2, c_OP_STB = 4'h3;
    localparam logic [3:0] c_OP_JSR = 4'h4, c_OP_AND = 4'h5, c_OP_LDR = 4'h6, c_OP_STR = 4'h7;
    localparam logic [3:0] c_OP_RTI = 4'h8, c_OP_NOT = 4'h9, c_OP_LDI = 4'hA, c_OP_STI = 4'hB;
    localparam logic [3:0] c_OP_JMP = 4'hC, c_OP_SHF = 4'hD, c_OP_LEA = 4'hE, c_OP_TRP = 4'hF;

    localparam logic [0:0] c_ST_ISSUE = 1'b0;
    localparam logic [0:0] c_ST_IND2  = 1'b1;

    function automatic lc3b_control_word f_decode(input logic [3:0] op, input logic b11,
                                                  input logic b5, input logic b4,
                                                  input logic second);
        lc3b_control_word w;
        w        = '0;
        w.aluop  = alu_pass;
        w.opcode = op;
        case (op)
            c_OP_ADD, c_OP_AND: begin
                w.aluop    = (op == c_OP_ADD) ? alu_add : alu_and;
                w.aluBmux  = b5;
                w.load_cc  = 1'b1;
                w.load_dst = 1'b1;
            end
            c_OP_NOT: begin
                w.aluop    = alu_not;
                w.load_cc  = 1'b1;
                w.load_dst = 1'b1;
            end
            c_OP_SHF: begin
                w.immmux   = 2'b01;
                w.aluBmux  = 1'b1;
                w.aluop    = !b4 ? alu_sll : (b5 ? alu_sra : alu_srl);
                w.load_cc  = 1'b1;
                w.load_dst = 1'b1;
            end
            c_OP_LDR, c_OP_LDB: begin
                w.immmux    = (op == c_OP_LDB) ? 2'b11 : 2'b10;
                w.aluBmux   = 1'b1;
                w.aluop     = alu_add;
                w.wbdatamux = 2'b01;
                w.load_cc   = 1'b1;
                w.load_dst  = 1'b1;
            end
            c_OP_STR, c_OP_STB: begin
                w.sr2mux  = 1'b1;
                w.immmux  = (op == c_OP_STB) ? 2'b11 : 2'b10;
                w.aluBmux = 1'b1;
                w.aluop   = alu_add;
            end
            c_OP_LDI, c_OP_STI: begin
                if (IND_EN == 0) begin
                    // Without indirection these behave exactly as LDR/STR
                    w.immmux  = 2'b10;
                    w.aluBmux = 1'b1;
                    w.aluop   = alu_add;
                    if (op == c_OP_LDI) begin
                        w.wbdatamux = 2'b01;
                        w.load_cc   = 1'b1;
                        w.load_dst  = 1'b1;
                    end else begin
                        w.sr2mux = 1'b1;
                    end
                end else if (!second) begin
                    // Pointer fetch: LDR addressing, nothing written back
                    w.immmux    = 2'b10;
                    w.aluBmux   = 1'b1;
                    w.aluop     = alu_add;
                    w.wbdatamux = 2'b01;
                end else if (op == c_OP_LDI) begin
                    w.wbdatamux = 2'b01;
                    w.load_cc   = 1'b1;
                    w.load_dst  = 1'b1;
                end else begin
                    w.sr2mux = 1'b1;
                end
            end
            c_OP_LEA: begin
                w.marmux   = 2'b01;
                w.load_cc  = 1'b1;
                w.load_dst = 1'b1;
            end
            c_OP_JSR: begin
                w.adjmux   = 1'b1;
                w.jsrmux   = b11;
                w.marmux   = 2'b10;
                w.dstmux   = 1'b1;
                w.load_dst = 1'b1;
            end
            c_OP_TRP: begin
                w.regAmux   = 1'b1;
                w.wbdatamux = 2'b10;
                w.dstmux    = 1'b1;
                w.load_dst  = 1'b1;
            end
            c_OP_BR, c_OP_JMP: ;
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST) ? '0 : ptr + 1'b1;
    endfunction

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_rd;
    logic [c_CNT_W-1:0] r_count;
    logic               r_illegal;
    logic [15:0]        r_hold_instr;
    logic [15:0]        r_hold_pc;
    entry_t             r_mem [DEPTH];

    logic   w_full;
    logic   w_in_ready;
    logic   w_accept;
    logic   w_push;
    logic   w_pop;
    logic   w_ind;
    entry_t w_push_entry;
    entry_t w_head;

    assign w_full   = (r_count == c_FULL);
    assign w_accept = bus.in_valid && w_in_ready;
    assign w_pop    = bus.out_ready && (r_count != '0) && !bus.flush;
    assign w_ind    = (IND_EN != 0) &&
                      ((bus.in_instr[15:12] == c_OP_LDI) || (bus.in_instr[15:12] == c_OP_STI));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_ISSUE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_push       = 1'b0;
        w_push_entry = '0;
        case (r_state)
            c_ST_ISSUE: begin
                w_in_ready = !w_full && !rst && !bus.flush;
                if (bus.in_valid && w_in_ready) begin
                    w_push             = 1'b1;
                    w_push_entry.ctrl  = f_decode(bus.in_instr[15:12], bus.in_instr[11],
                                                  bus.in_instr[5], bus.in_instr[4], 1'b0);
                    w_push_entry.instr = bus.in_instr;
                    w_push_entry.pc    = bus.in_pc;
                    if (w_ind) begin
                        w_state_next = c_ST_IND2;
                    end
                end
            end
            c_ST_IND2: begin
                if (!w_full && !rst && !bus.flush) begin
                    w_push             = 1'b1;
                    w_push_entry.ctrl  = f_decode(r_hold_instr[15:12], r_hold_instr[11],
                                                  r_hold_instr[5], r_hold_instr[4], 1'b1);
                    w_push_entry.instr = r_hold_instr;
                    w_push_entry.pc    = r_hold_pc;
                    w_push_entry.uop   = 1'b1;
                    w_state_next       = c_ST_ISSUE;
                end
            end
            default: w_state_next = c_ST_ISSUE;
        endcase
        if (bus.flush) begin
            w_state_next = c_ST_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && (bus.in_instr[15:12] == c_OP_RTI);
            if (w_push) begin
                r_wr <= f_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_next(r_rd);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload storage carries no reset; empty slots are masked at the head
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_push_entry;
        end
        if (w_accept) begin
            r_hold_instr <= bus.in_instr;
            r_hold_pc    <= bus.in_pc;
        end
    end

    assign w_head        = (r_count != '0) ? r_mem[r_rd] : '0;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_ctrl  = w_head.ctrl;
    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_uop   = w_head.uop;
    assign bus.count     = r_count;
    assign bus.illegal   = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_lc3b_decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lc3b_decode_queue                                                       |
// | Directed bench for the LC-3b decode queue (DEPTH=4, IND_EN=1).             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lc3b_decode_queue;
    localparam logic [2:0] c_ADD = 3'd0, c_AND = 3'd1, c_PASS = 3'd3, c_SRA = 3'd6;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] aluop;
        logic       aluBmux;
        logic [1:0] immmux;
        logic       sr2mux;
        logic [1:0] wbdatamux;
        logic [1:0] marmux;
        logic       adjmux;
        logic       jsrmux;
        logic       dstmux;
        logic       regAmux;
        logic       load_cc;
        logic       load_dst;
    } ctrl_t;

    logic  clk;
    logic  rst;
    int    n_cmp;
    int    n_err;
    ctrl_t head;

    lc3b_decode_queue_if #(.DEPTH(4)) bus ();

    lc3b_decode_queue #(.DEPTH(4), .IND_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign head = bus.out_ctrl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ctrl_t cw(input logic [3:0] op, input logic [2:0] alu, input logic bm,
                                 input logic [1:0] imm, input logic sr2, input logic [1:0] wb,
                                 input logic [1:0] mar, input logic adj, input logic jsr,
                                 input logic dst, input logic rega, input logic cc,
                                 input logic ld);
        return '{op, alu, bm, imm, sr2, wb, mar, adj, jsr, dst, rega, cc, ld};
    endfunction

    task automatic push(input logic [15:0] instr, input logic [15:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    logic [15:0] t_instr [6];
    ctrl_t       t_exp   [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_count", {29'd0, bus.count}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("rst_uop", {31'd0, bus.out_uop}, 32'd0);
        chk("rst_ctrl", {11'd0, bus.out_ctrl}, 32'd0);
        chk("rst_instr", {16'd0, bus.out_instr}, 32'd0);
        chk("rst_pc", {16'd0, bus.out_pc}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // ADD R1,R2,#3 through an empty queue
        bus.out_ready = 1'b1;
        push(16'h12A3, 16'h3000);
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_count", {29'd0, bus.count}, 32'd1);
        chk("add_ctrl", {11'd0, head},
            {11'd0, cw(4'h1, c_ADD, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1)});
        chk("add_uop", {31'd0, bus.out_uop}, 32'd0);
        chk("add_pc", {16'd0, bus.out_pc}, 32'h3000);
        chk("add_illegal", {31'd0, bus.illegal}, 32'd0);
        tick();
        chk("add_drain", {29'd0, bus.count}, 32'd0);

        // Single-uop decode table
        t_instr[0] = 16'hD031;
        t_exp[0]   = cw(4'hD, c_SRA, 1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
        t_instr[1] = 16'hE000;
        t_exp[1]   = cw(4'hE, c_PASS, 0, 2'b00, 0, 2'b00, 2'b01, 0, 0, 0, 0, 1, 1);
        t_instr[2] = 16'h4800;
        t_exp[2]   = cw(4'h4, c_PASS, 0, 2'b00, 0, 2'b00, 2'b10, 1, 1, 1, 0, 0, 1);
        t_instr[3] = 16'hF025;
        t_exp[3]   = cw(4'hF, c_PASS, 0, 2'b00, 0, 2'b10, 2'b00, 0, 0, 1, 1, 0, 1);
        t_instr[4] = 16'h3000;
        t_exp[4]   = cw(4'h3, c_ADD, 1, 2'b11, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        t_instr[5] = 16'hC1C0;
        t_exp[5]   = cw(4'hC, c_PASS, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            push(t_instr[i], 16'h3100);
            chk($sformatf("dec_%0d", i), {11'd0, head}, {11'd0, t_exp[i]});
            tick();
        end

        // LDI split into two uops
        bus.out_ready = 1'b0;
        bus.in_instr = 16'hA401;
        #1;
        chk("ldi_ready_pre", {31'd0, bus.in_ready}, 32'd1);
        push(16'hA401, 16'h3002);
        chk("ldi_count1", {29'd0, bus.count}, 32'd1);
        chk("ldi_ready_ind2", {31'd0, bus.in_ready}, 32'd0);
        chk("ldi_uop0_ctrl", {11'd0, head},
            {11'd0, cw(4'hA, c_ADD, 1, 2'b10, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0)});
        chk("ldi_uop0_uop", {31'd0, bus.out_uop}, 32'd0);
        tick();
        chk("ldi_count2", {29'd0, bus.count}, 32'd2);
        chk("ldi_ready_back", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("ldi_uop1_ctrl", {11'd0, head},
            {11'd0, cw(4'hA, c_PASS, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 1)});
        chk("ldi_uop1_uop", {31'd0, bus.out_uop}, 32'd1);
        chk("ldi_uop1_pc", {16'd0, bus.out_pc}, 32'h3002);
        tick();
        chk("ldi_drain", {29'd0, bus.count}, 32'd0);

        // Fill to DEPTH, then pop+push in the same cycle: push must be refused
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(16'h1042, 16'h3010 + 16'(2 * i));
        end
        chk("full_count", {29'd0, bus.count}, 32'd4);
        chk("full_bmux", {31'd0, head.aluBmux}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_pc = 16'h3018;
        #1;
        chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("full_pop_count", {29'd0, bus.count}, 32'd3);
        chk("full_pop_pc", {16'd0, bus.out_pc}, 32'h3012);
        tick();
        bus.in_valid = 1'b0;
        chk("full_late_count", {29'd0, bus.count}, 32'd3);
        chk("full_late_pc", {16'd0, bus.out_pc}, 32'h3014);
        tick();
        chk("full_order_1", {16'd0, bus.out_pc}, 32'h3016);
        tick();
        chk("full_order_2", {16'd0, bus.out_pc}, 32'h3018);
        tick();
        chk("full_empty", {29'd0, bus.count}, 32'd0);

        // STI fills slot 4, uop1 waits in IND2 for space, pointers wrap
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(16'h5020, 16'h3020 + 16'(2 * i));
        end
        chk("sti_and_alu", {29'd0, head.aluop}, {29'd0, c_AND});
        push(16'hB401, 16'h3026);
        chk("sti_count_full", {29'd0, bus.count}, 32'd4);
        tick();
        chk("sti_wait_count", {29'd0, bus.count}, 32'd4);
        chk("sti_wait_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("sti_pop_count", {29'd0, bus.count}, 32'd3);
        bus.out_ready = 1'b0;
        tick();
        chk("sti_uop1_count", {29'd0, bus.count}, 32'd4);
        chk("sti_head_pc", {16'd0, bus.out_pc}, 32'h3022);
        bus.out_ready = 1'b1;
        tick();
        chk("sti_seq_pc2", {16'd0, bus.out_pc}, 32'h3024);
        tick();
        chk("sti_uop0_pc", {16'd0, bus.out_pc}, 32'h3026);
        chk("sti_uop0_ctrl", {11'd0, head},
            {11'd0, cw(4'hB, c_ADD, 1, 2'b10, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0)});
        tick();
        chk("sti_uop1_pc", {16'd0, bus.out_pc}, 32'h3026);
        chk("sti_uop1_uop", {31'd0, bus.out_uop}, 32'd1);
        chk("sti_uop1_ctrl", {11'd0, head},
            {11'd0, cw(4'hB, c_PASS, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0)});
        tick();
        chk("sti_empty", {29'd0, bus.count}, 32'd0);

        // Flush while IND2 is pending with two entries queued
        bus.out_ready = 1'b0;
        push(16'h1042, 16'h3030);
        push(16'hA401, 16'h3032);
        chk("fl_pre_count", {29'd0, bus.count}, 32'd2);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h12A3;
        bus.in_pc = 16'h3034;
        #1;
        chk("fl_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("fl_count", {29'd0, bus.count}, 32'd0);
        chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_issue", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("fl_no_uop1", {29'd0, bus.count}, 32'd0);

        // RTI is illegal: zero control word and a one-cycle pulse
        push(16'h8000, 16'h3040);
        chk("rti_illegal", {31'd0, bus.illegal}, 32'd1);
        chk("rti_ctrl", {11'd0, bus.out_ctrl}, 32'd0);
        chk("rti_instr", {16'd0, bus.out_instr}, 32'h8000);
        tick();
        chk("rti_pulse_end", {31'd0, bus.illegal}, 32'd0);
        chk("rti_count", {29'd0, bus.count}, 32'd1);

        // Reset mid-stream
        push(16'h8000, 16'h3042);
        chk("mid_illegal", {31'd0, bus.illegal}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_count", {29'd0, bus.count}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("mid_rst_ctrl", {11'd0, bus.out_ctrl}, 32'd0);
        chk("mid_rst_pc", {16'd0, bus.out_pc}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
